video_dnn_frame_arbiter: RTL

- Shares one video DNN classifier pipeline (pixel-wise max-count classifier) between NUM_SRC AXI4-Stream video sources.
- Grants are made per whole frame, round-robin. The source ID is carried through the pipeline in upper tuser bits.
- Classified results returning from the pipeline are demultiplexed back to per-source result streams by that ID.
- Sits between the camera/DMA stream muxes and the classifier. Result outputs feed the per-source overlay/stat blocks.

---
 rtl/video_dnn_frame_arbiter_pkg.sv | 27 ++
 rtl/video_dnn_frame_arbiter_if.sv | 62 ++++++
 rtl/video_dnn_frame_arbiter_rr_select.sv | 35 +++
 rtl/video_dnn_frame_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/video_dnn_frame_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// video_dnn_pkg: shared constants, state encoding and width helpers for the
// video DNN frame arbiter.                                   Revision: 1.0
// ----------------------------------------------------------------------------
package video_dnn_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int id_width(input int num_src);
    return (num_src < 2) ? 1 : clog2(num_src);
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int SOF_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/video_dnn_frame_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// video_dnn_frame_arbiter_if: source, classifier and result stream bundle.
// slave = arbiter view, master = surrounding system view.     Revision: 1.0
// ----------------------------------------------------------------------------
interface video_dnn_frame_arbiter_if #(
  parameter int NUM_SRC       = 4,
  parameter int ID_WIDTH      = 2,
  parameter int TUSER_WIDTH   = 1,
  parameter int TDATA_WIDTH   = 80,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH  = 4
);
  logic [NUM_SRC*TUSER_WIDTH-1:0]   s_axi4s_tuser;
  logic [NUM_SRC-1:0]               s_axi4s_tlast;
  logic [NUM_SRC*TDATA_WIDTH-1:0]   s_axi4s_tdata;
  logic [NUM_SRC-1:0]               s_axi4s_tvalid;
  logic [NUM_SRC-1:0]               s_axi4s_tready;

  logic [ID_WIDTH+TUSER_WIDTH-1:0]  m_axi4s_tuser;
  logic                             m_axi4s_tlast;
  logic [TDATA_WIDTH-1:0]           m_axi4s_tdata;
  logic                             m_axi4s_tvalid;
  logic                             m_axi4s_tready;

  logic [ID_WIDTH+TUSER_WIDTH-1:0]  s_res_tuser;
  logic                             s_res_tlast;
  logic [TNUMBER_WIDTH-1:0]         s_res_tnumber;
  logic [TCOUNT_WIDTH-1:0]          s_res_tcount;
  logic                             s_res_tvalid;
  logic                             s_res_tready;

  logic [TUSER_WIDTH-1:0]           m_res_tuser;
  logic                             m_res_tlast;
  logic [TNUMBER_WIDTH-1:0]         m_res_tnumber;
  logic [TCOUNT_WIDTH-1:0]          m_res_tcount;
  logic [NUM_SRC-1:0]               m_res_tvalid;
  logic [NUM_SRC-1:0]               m_res_tready;

  modport slave (
    input  s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tvalid,
    output s_axi4s_tready,
    output m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata, m_axi4s_tvalid,
    input  m_axi4s_tready,
    input  s_res_tuser, s_res_tlast, s_res_tnumber, s_res_tcount, s_res_tvalid,
    output s_res_tready,
    output m_res_tuser, m_res_tlast, m_res_tnumber, m_res_tcount, m_res_tvalid,
    input  m_res_tready
  );

  modport master (
    output s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tvalid,
    input  s_axi4s_tready,
    input  m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata, m_axi4s_tvalid,
    output m_axi4s_tready,
    output s_res_tuser, s_res_tlast, s_res_tnumber, s_res_tcount, s_res_tvalid,
    input  s_res_tready,
    input  m_res_tuser, m_res_tlast, m_res_tnumber, m_res_tcount, m_res_tvalid,
    output m_res_tready
  );
endinterface
`default_nettype wire

// File: rtl/video_dnn_frame_arbiter_rr_select.sv
`default_nettype none
// ----------------------------------------------------------------------------
// video_dnn_rr_select: combinational round-robin picker, first request at or
// after ptr in cyclic order.                                 Revision: 1.0
// ----------------------------------------------------------------------------
module video_dnn_rr_select #(
  parameter int NUM_SRC  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_SRC-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] index
);

  logic [2*NUM_SRC-1:0] req_dbl;
  logic [NUM_SRC-1:0]   req_rot;

  // Doubling the vector turns the cyclic search into a plain priority scan.
  assign req_dbl = {req, req};
  assign req_rot = NUM_SRC'(req_dbl >> ptr);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!found && req_rot[j]) begin
        found = 1'b1;
        index = ID_WIDTH'((int'(ptr) + j) % NUM_SRC);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/video_dnn_frame_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// video_dnn_frame_arbiter: per-frame round-robin sharing of one classifier
// between NUM_SRC video sources, with result demux by ID.     Revision: 1.0
// ----------------------------------------------------------------------------
module video_dnn_frame_arbiter
  import video_dnn_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int ID_WIDTH      = id_width(NUM_SRC),
  parameter int TUSER_WIDTH   = 1,
  parameter int TDATA_WIDTH   = 80,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH  = 4,
  parameter int HEIGHT_WIDTH  = 12
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [HEIGHT_WIDTH-1:0]    param_height,
  video_dnn_frame_arbiter_if.slave   bus,
  output logic                       busy,
  output logic [ID_WIDTH-1:0]        grant_id
);

  logic [TUSER_WIDTH-1:0] src_tuser [NUM_SRC];
  logic [TDATA_WIDTH-1:0] src_tdata [NUM_SRC];
  logic [NUM_SRC-1:0]     src_sof;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
    assign src_tuser[k] = bus.s_axi4s_tuser[k*TUSER_WIDTH +: TUSER_WIDTH];
    assign src_tdata[k] = bus.s_axi4s_tdata[k*TDATA_WIDTH +: TDATA_WIDTH];
    assign src_sof[k]   = src_tuser[k][SOF_BIT];
  end

  arb_state_t              state;
  arb_state_t              state_next;
  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [ID_WIDTH-1:0]     grant_reg;
  logic [ID_WIDTH-1:0]     ptr_after;
  logic [HEIGHT_WIDTH-1:0] line_cnt;
  logic [HEIGHT_WIDTH-1:0] last_line;

  logic [NUM_SRC-1:0]      sof_req;
  logic                    req_found;
  logic [ID_WIDTH-1:0]     req_index;

  logic [NUM_SRC-1:0]      src_tready;
  logic                    fwd_tvalid;
  logic                    fwd_tlast;
  logic [TDATA_WIDTH-1:0]  fwd_tdata;
  logic [TUSER_WIDTH-1:0]  fwd_user;
  logic                    fwd_accept;
  logic                    frame_end;

  assign sof_req = bus.s_axi4s_tvalid & src_sof;

  video_dnn_rr_select #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_select (
    .req   (sof_req),
    .ptr   (rr_ptr),
    .found (req_found),
    .index (req_index)
  );

  always_comb begin
    state_next = state;
    src_tready = '0;
    fwd_tvalid = 1'b0;
    fwd_tlast  = 1'b0;
    fwd_tdata  = '0;
    fwd_user   = '0;
    fwd_accept = 1'b0;
    frame_end  = 1'b0;
    if (aresetn) begin
      case (state)
        IDLE: begin
          // Non-SOF beats are thrown away so a source re-aligns to a frame start.
          src_tready = bus.s_axi4s_tvalid & ~src_sof;
          if (req_found) state_next = BUSY;
        end
        BUSY: begin
          for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_reg == ID_WIDTH'(k)) begin
              fwd_tvalid    = bus.s_axi4s_tvalid[k];
              fwd_tlast     = bus.s_axi4s_tlast[k];
              fwd_tdata     = src_tdata[k];
              fwd_user      = src_tuser[k];
              src_tready[k] = bus.m_axi4s_tready;
            end
          end
          fwd_accept = fwd_tvalid & bus.m_axi4s_tready;
          frame_end  = fwd_accept & fwd_tlast & (line_cnt == last_line);
          if (frame_end) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign ptr_after = (grant_reg == ID_WIDTH'(NUM_SRC - 1)) ? '0 : grant_reg + 1'b1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_reg <= '0;
      line_cnt  <= '0;
      last_line <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_found) begin
        grant_reg <= req_index;
        line_cnt  <= '0;
        last_line <= (param_height == '0) ? '0 : param_height - 1'b1;
      end
      // A stray SOF inside the frame is deliberately not a counter reset.
      if (fwd_accept && fwd_tlast) begin
        if (frame_end) begin
          line_cnt <= '0;
          rr_ptr   <= ptr_after;
        end else begin
          line_cnt <= line_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.s_axi4s_tready = src_tready;
  assign bus.m_axi4s_tvalid = fwd_tvalid;
  assign bus.m_axi4s_tlast  = fwd_tlast;
  assign bus.m_axi4s_tdata  = fwd_tdata;
  assign bus.m_axi4s_tuser  = fwd_tvalid ? {grant_reg, fwd_user} : '0;

  assign busy     = (state == BUSY);
  assign grant_id = grant_reg;

  logic [ID_WIDTH-1:0] res_id;
  logic [NUM_SRC-1:0]  res_tvalid;
  logic                res_tready;

  assign res_id = bus.s_res_tuser[TUSER_WIDTH +: ID_WIDTH];

  // Ids with no matching source fall through with ready=1 and are dropped.
  always_comb begin
    res_tvalid = '0;
    res_tready = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (res_id == ID_WIDTH'(k)) begin
        res_tvalid[k] = bus.s_res_tvalid;
        res_tready    = bus.m_res_tready[k];
      end
    end
  end

  assign bus.s_res_tready  = res_tready;
  assign bus.m_res_tvalid  = res_tvalid;
  assign bus.m_res_tuser   = bus.s_res_tuser[TUSER_WIDTH-1:0];
  assign bus.m_res_tlast   = bus.s_res_tlast;
  assign bus.m_res_tnumber = bus.s_res_tnumber;
  assign bus.m_res_tcount  = bus.s_res_tcount;

endmodule
`default_nettype wire
